ws2812b_tx_encoder: RTL

Serial transmitter for the WS2812B single-wire LED protocol, the sending end of the link whose receive side ends in the idle/latch detector. It accepts pixels over a valid/ready handshake and shifts them out MSB-first as NRZ-width-coded bits. Each bit has a programmable high time and period. After the last pixel of a frame it holds the line low for a programmable latch gap. It sits between the peripheral register/FIFO front-end and the `dout` pad.

---
 rtl/ws2812b_pkg.sv | 23 ++
 rtl/ws2812b_phase_timer.sv | 36 +++
 rtl/ws2812b_tx_encoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
`default_nettype none
// ============================================================================
// ws2812b_pkg : shared FSM type, default widths and clamp minimums for the link
// Rev 1.0
// ============================================================================
package ws2812b_pkg;

  localparam int DEF_PIXEL_BITS = 24;
  localparam int DEF_TICK_W     = 16;

  // Minimum bit period and latch length, also used by the idle detector setup
  localparam int P_MIN = 2;
  localparam int L_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/ws2812b_phase_timer.sv
`default_nettype none
// ============================================================================
// ws2812b_phase_timer : loadable down-counter, phase_end high in a phase's last cycle
// Rev 1.0
// ============================================================================
module ws2812b_phase_timer
  import ws2812b_pkg::*;
#(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TICK_W-1:0] length,
  output logic              phase_end
);

  localparam logic [TICK_W-1:0] C_ONE = TICK_W'(1);

  logic [TICK_W-1:0] r_cnt;

  // Counter holds at zero between phases, so phase_end cannot fire spuriously
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= length;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign phase_end = (r_cnt == C_ONE);

endmodule
`default_nettype wire

// File: rtl/ws2812b_tx_encoder.sv
`default_nettype none
// ============================================================================
// ws2812b_tx_encoder : WS2812B pixel serialiser; WS2812B_TX_RGB_REORDER_EN maps {R,G,B} to GRB
// Rev 1.0
// ============================================================================
module ws2812b_tx_encoder
  import ws2812b_pkg::*;
#(
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int TICK_W     = DEF_TICK_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_last,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic [TICK_W-1:0]     t0h_ticks,
  input  logic [TICK_W-1:0]     t1h_ticks,
  input  logic [TICK_W-1:0]     bit_ticks,
  input  logic [TICK_W-1:0]     latch_ticks,
  output logic                  dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int                CNT_W     = $clog2(PIXEL_BITS);
  localparam int                MSB       = PIXEL_BITS - 1;
  localparam logic [CNT_W-1:0]  C_CNT_TOP = CNT_W'(PIXEL_BITS - 1);
  localparam logic [TICK_W-1:0] C_ONE     = TICK_W'(1);
  localparam logic [TICK_W-1:0] C_P_MIN   = TICK_W'(P_MIN);
  localparam logic [TICK_W-1:0] C_L_MIN   = TICK_W'(L_MIN);

  function automatic logic [TICK_W-1:0] clamp_high(input logic [TICK_W-1:0] t,
                                                   input logic [TICK_W-1:0] p);
    if (t == '0)     return C_ONE;
    else if (t >= p) return p - C_ONE;
    else             return t;
  endfunction

  tx_state_t             r_state, w_state_next;
  logic [PIXEL_BITS-1:0] r_shift, w_shift_next, w_pixel_wire;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
  logic                  r_last, w_last_next;
  logic [TICK_W-1:0]     r_p, r_h0, r_h1, r_l;
  logic [TICK_W-1:0]     w_p_in, w_h0_in, w_h1_in, w_l_in, w_h_cur;
  logic                  w_tmr_load, w_phase_end;
  logic [TICK_W-1:0]     w_tmr_len;

`ifdef WS2812B_TX_RGB_REORDER_EN
  assign w_pixel_wire = {pixel_data[15:8], pixel_data[23:16], pixel_data[7:0]};
`else
  assign w_pixel_wire = pixel_data;
`endif

  // Clamped view of the live timing inputs; only captured on a frame start
  assign w_p_in  = (bit_ticks < C_P_MIN) ? C_P_MIN : bit_ticks;
  assign w_h0_in = clamp_high(t0h_ticks, w_p_in);
  assign w_h1_in = clamp_high(t1h_ticks, w_p_in);
  assign w_l_in  = (latch_ticks < C_L_MIN) ? C_L_MIN : latch_ticks;
  assign w_h_cur = r_shift[MSB] ? r_h1 : r_h0;

  ws2812b_phase_timer #(
    .TICK_W (TICK_W)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_tmr_load),
    .length    (w_tmr_len),
    .phase_end (w_phase_end)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_last_next    = r_last;
    w_tmr_load     = 1'b0;
    w_tmr_len      = '0;
    pixel_ready    = 1'b0;
    frame_done     = 1'b0;
    underrun       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pixel_ready = 1'b1;
        if (pixel_valid) begin
          w_shift_next   = w_pixel_wire;
          w_bit_cnt_next = C_CNT_TOP;
          w_last_next    = pixel_last;
          w_state_next   = ST_HIGH;
          w_tmr_load     = 1'b1;
          w_tmr_len      = w_pixel_wire[MSB] ? w_h1_in : w_h0_in;
        end
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_state_next = ST_LOW;
          w_tmr_load   = 1'b1;
          w_tmr_len    = r_p - w_h_cur;
        end
      end
      ST_LOW: begin
        if (w_phase_end) begin
          if (r_bit_cnt != '0) begin
            w_shift_next   = {r_shift[MSB-1:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt - CNT_W'(1);
            w_state_next   = ST_HIGH;
            w_tmr_load     = 1'b1;
            w_tmr_len      = w_shift_next[MSB] ? r_h1 : r_h0;
          end else if (r_last) begin
            w_state_next = ST_LATCH;
            w_tmr_load   = 1'b1;
            w_tmr_len    = r_l;
          end else begin
            // Follower pixel is taken in the very last LOW cycle so the stream stays gap-free
            pixel_ready = 1'b1;
            if (pixel_valid) begin
              w_shift_next   = w_pixel_wire;
              w_bit_cnt_next = C_CNT_TOP;
              w_last_next    = pixel_last;
              w_state_next   = ST_HIGH;
              w_tmr_load     = 1'b1;
              w_tmr_len      = w_pixel_wire[MSB] ? r_h1 : r_h0;
            end else begin
              underrun     = ~reset;
              w_state_next = ST_IDLE;
            end
          end
        end
      end
      ST_LATCH: begin
        if (w_phase_end) begin
          frame_done   = ~reset;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_p       <= '0;
      r_h0      <= '0;
      r_h1      <= '0;
      r_l       <= '0;
      dout      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_last    <= w_last_next;
      dout      <= (w_state_next == ST_HIGH);
      if (r_state == ST_IDLE && pixel_valid) begin
        r_p  <= w_p_in;
        r_h0 <= w_h0_in;
        r_h1 <= w_h1_in;
        r_l  <= w_l_in;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
